fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Fetch-stage controller that owns the PC register and sequences instruction fetch.
//  Issues req/ack reads to instruction memory and advances the PC by 4 or redirects to a branch target.
//  Honours hazard-unit stalls and flushes IF/ID on redirect.
//  Drains and discards a stale in-flight fetch after a redirect.
// PARAMETERS
//  RESET_PC   0    PC value loaded on reset (must be 4-aligned)
//  CNT_W      32   width of saturating wait-cycle perf counter
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  rst          in   1      reset, synchronous, active-low (0 = reset)
//  stall        in   1      hazard unit: hold PC, do not consume fetched instruction
//  br_taken     in   1      redirect request (branch resolved taken / BL / BR)
//  br_target    in   64     redirect address; bits [1:0] forced to 0 internally
//  imem_ack     in   1      imem data valid this cycle for the outstanding request
//  imem_req     out  1      read request; address held stable until imem_ack
//  imem_addr    out  64     fetch address
//  inst_valid   out  1      fetched word is good; IF/ID captures this cycle
//  flush_ifid   out  1      squash IF/ID contents this cycle
//  currPC       out  64     PC of instruction currently being fetched
//  pc_plus4     out  64     currPC + 4 (for BL link value)
//  fsm_state    out  2      debug: IDLE=0 FETCH=1 WAIT=2 DRAIN=3
//  wait_cnt     out  CNT_W  cycles spent in WAIT since reset; saturates at all-ones
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - currPC=RESET_PC, fsm_state=IDLE, wait_cnt=0, pending_addr=0.
//   - Combinational outputs are therefore imem_req=0, inst_valid=0, flush_ifid=0.
//   - Reset overrides everything, including a reset asserted mid-WAIT or mid-DRAIN.
//  IDLE: imem_req=0. Goes to FETCH next cycle unconditionally, giving a single boot bubble.
//  FETCH/WAIT (shared rules):
//   - imem_req=1, imem_addr=currPC.
//   - FETCH is the first cycle of a request; WAIT is every later cycle of that request.
//   - Priority: br_taken > stall > imem_ack.
//  br_taken, with imem_ack=1 or from FETCH:
//   - flush_ifid=1, inst_valid=0.
//   - currPC<=br_target&~3; next state FETCH.
//  br_taken in WAIT with imem_ack=0:
//   - flush_ifid=1.
//   - pending_addr<=currPC, currPC<=br_target&~3; next state DRAIN.
//  stall=1 (no br_taken):
//   - currPC held, inst_valid=0.
//   - Any ack this cycle is dropped and the request is re-issued at the same address; next state FETCH.
//  imem_ack=1, stall=0:
//   - inst_valid=1 (same cycle as ack).
//   - currPC<=currPC+4; next state FETCH.
//  imem_ack=0, no br_taken, no stall: next state WAIT, currPC held.
//  DRAIN:
//   - imem_req=1, imem_addr=pending_addr (the stale request completes untouched).
//   - inst_valid=0 and flush_ifid=0, except that br_taken in DRAIN gives flush_ifid=1.
//   - br_taken in DRAIN: currPC<=new target (latest wins); stay in DRAIN.
//   - imem_ack in DRAIN: the data is discarded; next state FETCH at currPC.
//  Latency: with imem_ack the same cycle as req, one instruction per cycle and zero bubbles.
//  Redirect cost: one bubble from FETCH; from WAIT, the remaining memory latency plus one.
//  Arithmetic:
//   - pc_plus4=currPC+4, combinational, modulo 2^64.
//   - 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
//  wait_cnt increments in each cycle with fsm_state==WAIT and holds at 2^CNT_W-1.
//  imem_ack is ignored in IDLE.
// TESTING
//  1. rst=0 for 2 cycles, RESET_PC=0 -> currPC=0, imem_req=0, fsm_state=0;
//     after release: 1 IDLE cycle, then FETCH with imem_addr=0.
//  2. imem_ack tied 1 for 10 cycles -> currPC 0,4,...,36; inst_valid=1 every cycle; wait_cnt=0.
//  3. At PC=8, hold ack 0 for 3 cycles, then pulse 1 -> state 1,2,2,2, inst_valid on 4th cycle;
//     currPC then 12; wait_cnt=3.
//  4. FETCH with ack=1, br_taken=1, br_target=300 -> flush_ifid=1, inst_valid=0, next currPC=300;
//     br_target=303 -> currPC=300.
//  5. In WAIT at PC=0x40, br_taken with target 0x100 -> DRAIN, imem_addr stays 0x40;
//     ack 2 cycles later is discarded (inst_valid=0); next cycle FETCH, imem_addr=0x100.
//  6. stall=1 with ack=1 at PC=0x20 -> PC held, inst_valid=0, re-request 0x20;
//     currPC=0xFFFF_FFFF_FFFF_FFFC with ack -> currPC=0;
//     rst=0 during DRAIN -> IDLE, currPC=RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC owner: issues req/ack imem reads, follows redirects,
// honours stalls and drains a stale in-flight fetch after a redirect.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [63:0]      br_target,
  input  logic             imem_ack,
  output logic             imem_req,
  output logic [63:0]      imem_addr,
  output logic             inst_valid,
  output logic             flush_ifid,
  output logic [63:0]      currPC,
  output logic [63:0]      pc_plus4,
  output logic [1:0]       fsm_state,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [63:0]      pend_q, pend_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [63:0]      tgt;

  assign tgt = {br_target[63:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    inst_valid = 1'b0;
    flush_ifid = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH, WAIT: begin
        if (br_taken) begin
          flush_ifid = 1'b1;
          pc_d       = tgt;
          // An unacked request from WAIT is still live in imem
          if (state_q == WAIT && !imem_ack) begin
            pend_d  = pc_q;
            state_d = DRAIN;
          end else begin
            state_d = FETCH;
          end
        end else if (stall) begin
          state_d = FETCH;
        end else if (imem_ack) begin
          inst_valid = 1'b1;
          pc_d       = pc_q + 64'd4;
          state_d    = FETCH;
        end else begin
          state_d = WAIT;
        end
      end
      DRAIN: begin
        if (br_taken) begin
          flush_ifid = 1'b1;
          pc_d       = tgt;
        end
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q == WAIT && !(&wcnt_q))
      wcnt_d = wcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= 64'h0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = (state_q == DRAIN) ? pend_q : pc_q;
  assign currPC    = pc_q;
  assign pc_plus4  = pc_q + 64'd4;
  assign fsm_state = state_q;
  assign wait_cnt  = wcnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a request-age based
// reference model checked every cycle.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic        imem_ack;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        inst_valid;
  logic        flush_ifid;
  logic [63:0] currPC;
  logic [63:0] pc_plus4;
  logic [1:0]  fsm_state;
  logic [31:0] wait_cnt;

  fetch_sequencer #(.RESET_PC(64'h0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .imem_ack(imem_ack), .imem_req(imem_req),
    .imem_addr(imem_addr), .inst_valid(inst_valid),
    .flush_ifid(flush_ifid), .currPC(currPC),
    .pc_plus4(pc_plus4), .fsm_state(fsm_state),
    .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: a request has an age (cycles since issue); a redirect that
  // catches an unacked request older than one cycle leaves it stale.
  logic [63:0] m_pc;
  logic        m_booted;
  int          m_age;
  logic        m_stale;
  logic [63:0] m_stale_addr;
  longint      m_waits;
  logic        m_known = 1'b0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic step(logic r, logic s, logic b,
                      logic [63:0] t, logic a);
    logic [1:0] e_st;
    logic       e_val, e_fl;
    rst = r; stall = s; br_taken = b;
    br_target = t; imem_ack = a;
    #2;
    if (m_known) begin
      e_st  = !m_booted ? 2'd0 : m_stale ? 2'd3 :
              (m_age == 0) ? 2'd1 : 2'd2;
      e_val = m_booted && !m_stale && !b && !s && a;
      e_fl  = m_booted && b;
      chk("state", 64'(fsm_state), 64'(e_st));
      chk("req", 64'(imem_req), 64'(m_booted));
      if (m_booted)
        chk("addr", imem_addr, m_stale ? m_stale_addr : m_pc);
      chk("valid", 64'(inst_valid), 64'(e_val));
      chk("flush", 64'(flush_ifid), 64'(e_fl));
      chk("pc", currPC, m_pc);
      chk("pc4", pc_plus4, m_pc + 64'd4);
      chk("wcnt", 64'(wait_cnt), 64'(m_waits));
    end
    @(posedge clk);
    if (!r) begin
      m_pc = 64'h0; m_booted = 1'b0; m_age = 0;
      m_stale = 1'b0; m_stale_addr = 64'h0;
      m_waits = 0; m_known = 1'b1;
    end else if (!m_booted) begin
      m_booted = 1'b1; m_age = 0;
    end else if (m_stale) begin
      if (b) m_pc = t & ~64'd3;
      if (a) begin m_stale = 1'b0; m_age = 0; end
    end else begin
      if (m_age > 0 && m_waits < 64'hFFFF_FFFF) m_waits++;
      if (b) begin
        if (m_age > 0 && !a) begin
          m_stale = 1'b1; m_stale_addr = m_pc;
        end
        m_pc = t & ~64'd3; m_age = 0;
      end else if (s) begin
        m_age = 0;
      end else if (a) begin
        m_pc = m_pc + 64'd4; m_age = 0;
      end else begin
        m_age++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset and boot bubble
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("boot_state", 64'(fsm_state), 64'd1);
    chk("boot_addr", imem_addr, 64'd0);
    // Zero-latency streaming
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1);
    chk("stream_pc", currPC, 64'd40);
    chk("stream_wcnt", 64'(wait_cnt), 64'd0);
    // Wait states at PC=8
    step(1, 0, 1, 64'd8, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    chk("wait_pc", currPC, 64'd12);
    chk("wait_cnt3", 64'(wait_cnt), 64'd3);
    // Redirect from FETCH, target alignment
    step(1, 0, 1, 64'd300, 1);
    chk("br_pc", currPC, 64'd300);
    step(1, 0, 1, 64'd303, 1);
    chk("br_align", currPC, 64'd300);
    // Redirect from WAIT then drain
    step(1, 0, 1, 64'h40, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 64'h100, 0);
    chk("drain_st", 64'(fsm_state), 64'd3);
    chk("drain_addr", imem_addr, 64'h40);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    chk("post_drain_st", 64'(fsm_state), 64'd1);
    chk("post_drain_addr", imem_addr, 64'h100);
    // Stall drops ack
    step(1, 0, 1, 64'h20, 0);
    step(1, 1, 0, 0, 1);
    chk("stall_pc", currPC, 64'h20);
    chk("stall_addr", imem_addr, 64'h20);
    step(1, 0, 0, 0, 1);
    // PC wraparound
    step(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    chk("wrap_pc4", pc_plus4, 64'd0);
    step(1, 0, 0, 0, 1);
    chk("wrap_pc", currPC, 64'd0);
    // Redirect in DRAIN, then reset mid-DRAIN
    step(1, 0, 1, 64'h40, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 64'h80, 0);
    step(1, 0, 1, 64'h90, 0);
    chk("drain_latest", currPC, 64'h90);
    step(0, 0, 0, 0, 0);
    chk("rst_state", 64'(fsm_state), 64'd0);
    chk("rst_pc", currPC, 64'd0);
    chk("rst_wcnt", 64'(wait_cnt), 64'd0);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    chk("final_pc", currPC, 64'd12);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_fail);
    $finish;
  end

endmodule
